// File: rtl/instruction_memory_sync.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory_sync
// Description : Synchronous-read instruction memory with a self-clearing
//               init sequence, fetch handshake, program-load port and fault
//               reporting. Optional boot program: IMEM_BOOT_PROGRAM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_memory_sync #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 8,
    parameter logic [XLEN-1:0] NOP_WORD = XLEN'(32'h0000_0013),
    localparam int             ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [XLEN-1:0]   fetch_pc,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [XLEN-1:0]   fetch_instr,
    output logic [1:0]        fetch_fault,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [XLEN-1:0]   prog_data,
    output logic              prog_busy
);

    localparam logic [1:0]        c_ST_INIT  = 2'd0;
    localparam logic [1:0]        c_ST_BOOT  = 2'd1;
    localparam logic [1:0]        c_ST_READY = 2'd2;
    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        c_FLT_OK   = 2'b00;
    localparam logic [1:0]        c_FLT_MIS  = 2'b01;
    localparam logic [1:0]        c_FLT_OOR  = 2'b10;

`ifdef IMEM_BOOT_PROGRAM_EN
    localparam logic [ADDR_W-1:0] c_BOOT_LAST = ADDR_W'(2);

    generate
        if (DEPTH < 3) begin : g_boot_depth_check
            $error("IMEM_BOOT_PROGRAM_EN requires DEPTH >= 3");
        end
    endgenerate

    function automatic logic [XLEN-1:0] boot_word(input logic [ADDR_W-1:0] idx);
        case (idx)
            ADDR_W'(0): boot_word = XLEN'(32'h00A0_0093);
            ADDR_W'(1): boot_word = XLEN'(32'h00B0_0113);
            ADDR_W'(2): boot_word = XLEN'(32'h0020_81B3);
            default:    boot_word = NOP_WORD;
        endcase
    endfunction
`endif

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]   mem_q [DEPTH];
    logic [XLEN-1:0]   mem_d [DEPTH];
    logic              fetch_valid_q, fetch_valid_d;
    logic [XLEN-1:0]   fetch_instr_q, fetch_instr_d;
    logic [1:0]        fetch_fault_q, fetch_fault_d;
    logic              w_accept;
    logic [XLEN-1:0]   w_word_idx;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; cnt walks the array in INIT and the boot words in BOOT
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_ST_INIT: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == c_LAST_IDX) begin
                    cnt_d = '0;
`ifdef IMEM_BOOT_PROGRAM_EN
                    state_d = c_ST_BOOT;
`else
                    state_d = c_ST_READY;
`endif
                end
            end
`ifdef IMEM_BOOT_PROGRAM_EN
            c_ST_BOOT: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == c_BOOT_LAST) begin
                    cnt_d   = '0;
                    state_d = c_ST_READY;
                end
            end
`endif
            default: ;
        endcase
    end

    // Handshake outputs; reset forces the not-ready view even from READY
    always_comb begin
        prog_busy   = reset || (state_q != c_ST_READY);
        fetch_ready = !reset && (state_q == c_ST_READY) && !prog_we;
    end

    always_comb begin
        mem_d = mem_q;
        case (state_q)
            c_ST_INIT: mem_d[cnt_q] = NOP_WORD;
`ifdef IMEM_BOOT_PROGRAM_EN
            c_ST_BOOT: mem_d[cnt_q] = boot_word(cnt_q);
`endif
            c_ST_READY: begin
                if (prog_we && (32'(prog_addr) < DEPTH)) begin
                    mem_d[prog_addr] = prog_data;
                end
            end
            default: ;
        endcase
    end

    assign w_accept   = fetch_req && fetch_ready;
    assign w_word_idx = fetch_pc >> 2;

    // Range check uses the full PC so high addresses never alias into the array
    always_comb begin
        fetch_valid_d = w_accept;
        fetch_instr_d = fetch_instr_q;
        fetch_fault_d = fetch_fault_q;
        if (w_accept) begin
            if (fetch_pc[1:0] != 2'b00) begin
                fetch_fault_d = c_FLT_MIS;
                fetch_instr_d = NOP_WORD;
            end else if (w_word_idx >= XLEN'(DEPTH)) begin
                fetch_fault_d = c_FLT_OOR;
                fetch_instr_d = NOP_WORD;
            end else begin
                fetch_fault_d = c_FLT_OK;
                fetch_instr_d = mem_q[w_word_idx[ADDR_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_valid_q <= 1'b0;
            fetch_instr_q <= NOP_WORD;
            fetch_fault_q <= c_FLT_OK;
        end else begin
            fetch_valid_q <= fetch_valid_d;
            fetch_instr_q <= fetch_instr_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    // Array is cleared only by the INIT sequence, never by reset directly
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q <= mem_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_instr = fetch_instr_q;
    assign fetch_fault = fetch_fault_q;

endmodule
`default_nettype wire
